// File: rtl/ergs_pkg.sv
// Shared types and widths for the erg stroke-phase sequencer.
package ergs_pkg;

    localparam int PHASE_W      = 2;
    localparam int STROKE_CNT_W = 16;

    typedef enum logic [PHASE_W-1:0] {
        IDLE     = 2'd0,
        DRIVE    = 2'd1,
        RECOVERY = 2'd2
    } phase_t;

endpackage

// File: rtl/tach_debounce.sv
// Two-flop synchroniser plus level debouncer for the raw tach input;
// rise_o is a registered one-cycle pulse on each debounced rising edge.
module tach_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tach_i,
    output logic rise_o
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [1:0]    sync_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == LAST) begin
                deb_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous, sampled on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], tach_i};
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
            rise_q <= deb_d & ~deb_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/stroke_phase_ctrl.sv
// Flywheel drive/recovery sequencer: interval measurement, accel/decel classifier and phase FSM.
// Optional stroke-period counter is built when STROKE_PERIOD_EN is defined.
module stroke_phase_ctrl
    import ergs_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DEBOUNCE     = 4,
    parameter int MIN_INTERVAL = 16,
    parameter int MARGIN       = 2,
    parameter int ACCEL_N      = 2,
    parameter int DECEL_N      = 2,
    parameter int TIMEOUT      = 1000000
) (
    input  logic                    count_clock,
    input  logic                    reset_n,
    input  logic                    tach_in,
    output logic                    start_drive,
    output logic                    start_recovery,
    output logic [PHASE_W-1:0]      phase,
    output logic [STROKE_CNT_W-1:0] stroke_count,
    output logic [CNT_W-1:0]        last_interval,
    output logic                    idle,
    output logic [CNT_W-1:0]        stroke_period
);

    localparam int RUN_MAX = (ACCEL_N > DECEL_N) ? ACCEL_N : DECEL_N;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_IV    = CNT_W'(MIN_INTERVAL);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   MARGIN_X  = (CNT_W + 1)'(MARGIN);
    localparam logic [RUN_W-1:0] RUN_MAX_V = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] ACCEL_V   = RUN_W'(ACCEL_N);
    localparam logic [RUN_W-1:0] DECEL_V   = RUN_W'(DECEL_N);

    logic tach_rise;

    tach_debounce #(.DEBOUNCE(DEBOUNCE)) u_tach_debounce (
        .clk    (count_clock),
        .rst_n  (reset_n),
        .tach_i (tach_in),
        .rise_o (tach_rise)
    );

    phase_t                  phase_q, phase_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        last_q, last_d;
    logic                    prev_valid_q, prev_valid_d;
    logic [RUN_W-1:0]        acc_q, acc_d, dec_q, dec_d;
    logic [RUN_W-1:0]        acc_n, dec_n;
    logic [STROKE_CNT_W-1:0] strokes_q, strokes_d;
    logic                    sd_q, sd_d, sr_q, sr_d;

    logic             accept, timeout_hit, accel, decel;
    logic [CNT_W:0]   cur_x, prev_x;

    // Compares run one bit wider so cur+MARGIN cannot wrap on a saturated interval.
    always_comb begin
        accept      = tach_rise && (cnt_q >= MIN_IV);
        timeout_hit = !accept && (cnt_q == TIMEOUT_V);
        cur_x       = {1'b0, cnt_q};
        prev_x      = {1'b0, last_q};
        accel       = (cur_x + MARGIN_X) < prev_x;
        decel       = cur_x > (prev_x + MARGIN_X);
    end

    always_comb begin
        phase_d      = phase_q;
        cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        last_d       = last_q;
        prev_valid_d = prev_valid_q;
        acc_d        = acc_q;
        dec_d        = dec_q;
        acc_n        = acc_q;
        dec_n        = dec_q;
        strokes_d    = strokes_q;
        sd_d         = 1'b0;
        sr_d         = 1'b0;

        if (accept) begin
            cnt_d        = CNT_W'(1);
            last_d       = cnt_q;
            prev_valid_d = 1'b1;
            if (prev_valid_q) begin
                if (accel) begin
                    acc_n = (acc_q == RUN_MAX_V) ? acc_q : acc_q + RUN_W'(1);
                    dec_n = '0;
                end else if (decel) begin
                    dec_n = (dec_q == RUN_MAX_V) ? dec_q : dec_q + RUN_W'(1);
                    acc_n = '0;
                end
                acc_d = acc_n;
                dec_d = dec_n;
                if (phase_q != DRIVE && acc_n == ACCEL_V) begin
                    phase_d   = DRIVE;
                    sd_d      = 1'b1;
                    strokes_d = strokes_q + STROKE_CNT_W'(1);
                    acc_d     = '0;
                    dec_d     = '0;
                end else if (phase_q == DRIVE && dec_n == DECEL_V) begin
                    phase_d = RECOVERY;
                    sr_d    = 1'b1;
                    acc_d   = '0;
                    dec_d   = '0;
                end
            end
        end else if (timeout_hit) begin
            phase_d      = IDLE;
            prev_valid_d = 1'b0;
            acc_d        = '0;
            dec_d        = '0;
        end
    end

    always_ff @(posedge count_clock) begin
        if (!reset_n) begin
            phase_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= '0;
            prev_valid_q <= 1'b0;
            acc_q        <= '0;
            dec_q        <= '0;
            strokes_q    <= '0;
            sd_q         <= 1'b0;
            sr_q         <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            prev_valid_q <= prev_valid_d;
            acc_q        <= acc_d;
            dec_q        <= dec_d;
            strokes_q    <= strokes_d;
            sd_q         <= sd_d;
            sr_q         <= sr_d;
        end
    end

`ifdef STROKE_PERIOD_EN
    // A zero count means no DRIVE entry since reset/IDLE, so the period is left untouched.
    logic [CNT_W-1:0] sp_cnt_q, sp_cnt_d, sp_q, sp_d;

    always_comb begin
        sp_cnt_d = sp_cnt_q;
        sp_d     = sp_q;
        if (sd_d) begin
            if (sp_cnt_q != '0) begin
                sp_d = sp_cnt_q;
            end
            sp_cnt_d = CNT_W'(1);
        end else if (timeout_hit) begin
            sp_cnt_d = '0;
        end else if (sp_cnt_q != '0 && sp_cnt_q != CNT_MAX) begin
            sp_cnt_d = sp_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge count_clock) begin
        if (!reset_n) begin
            sp_cnt_q <= '0;
            sp_q     <= '0;
        end else begin
            sp_cnt_q <= sp_cnt_d;
            sp_q     <= sp_d;
        end
    end

    assign stroke_period = sp_q;
`else
    assign stroke_period = '0;
`endif

    assign start_drive    = sd_q;
    assign start_recovery = sr_q;
    assign phase          = phase_q;
    assign idle           = (phase_q == IDLE);
    assign stroke_count   = strokes_q;
    assign last_interval  = last_q;

endmodule

// File: tb/tb_stroke_phase_ctrl.sv
// Self-checking bench for stroke_phase_ctrl: directed scenarios plus randomized tach traffic,
// compared every cycle against a time-stamp based behavioural model.
module tb_stroke_phase_ctrl;

    localparam int CNT_W        = 16;
    localparam int DEBOUNCE     = 4;
    localparam int MIN_INTERVAL = 16;
    localparam int MARGIN       = 2;
    localparam int ACCEL_N      = 2;
    localparam int DECEL_N      = 2;
    localparam int TIMEOUT      = 2000;
    localparam int RUN_MAX      = (ACCEL_N > DECEL_N) ? ACCEL_N : DECEL_N;
    // Rise first sampled one edge after it is driven, two sync flops, DEBOUNCE samples,
    // registered rise pulse: the event is processed EV_LAT edges after the driving edge.
    localparam int EV_LAT       = DEBOUNCE + 3;
    localparam longint CNT_SAT  = (64'd1 << CNT_W) - 1;

    logic              count_clock = 1'b0;
    logic              reset_n;
    logic              tach_in;
    logic              start_drive;
    logic              start_recovery;
    logic [1:0]        phase;
    logic [15:0]       stroke_count;
    logic [CNT_W-1:0]  last_interval;
    logic              idle;
    logic [CNT_W-1:0]  stroke_period;

    always #5 count_clock = ~count_clock;

    stroke_phase_ctrl #(
        .CNT_W        (CNT_W),
        .DEBOUNCE     (DEBOUNCE),
        .MIN_INTERVAL (MIN_INTERVAL),
        .MARGIN       (MARGIN),
        .ACCEL_N      (ACCEL_N),
        .DECEL_N      (DECEL_N),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .count_clock    (count_clock),
        .reset_n        (reset_n),
        .tach_in        (tach_in),
        .start_drive    (start_drive),
        .start_recovery (start_recovery),
        .phase          (phase),
        .stroke_count   (stroke_count),
        .last_interval  (last_interval),
        .idle           (idle),
        .stroke_period  (stroke_period)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: intervals are differences of edge time stamps, not a counter.
    longint cyc = 0;
    bit     m_valid = 1'b0;
    longint anchor, last_iv, period, last_drive;
    bit     prev_valid, drive_valid, m_sd, m_sr;
    int     acc, dec, ph, strokes;
    longint ev_q[$];

    always @(posedge count_clock) begin : model
        longint iv;
        bit     hit;
        cyc++;
        m_sd = 1'b0;
        m_sr = 1'b0;
        if (!reset_n) begin
            m_valid     = 1'b1;
            anchor      = cyc + 1;
            prev_valid  = 1'b0;
            last_iv     = 0;
            acc         = 0;
            dec         = 0;
            ph          = 0;
            strokes     = 0;
            period      = 0;
            last_drive  = 0;
            drive_valid = 1'b0;
            ev_q.delete();
        end else if (m_valid) begin
            iv = cyc - anchor;
            if (iv > CNT_SAT) iv = CNT_SAT;
            hit = 1'b0;
            if (ev_q.size() > 0 && ev_q[0] == cyc) begin
                hit = 1'b1;
                void'(ev_q.pop_front());
            end
            if (hit && iv >= MIN_INTERVAL) begin
                if (prev_valid) begin
                    if (iv + MARGIN < last_iv) begin
                        acc = (acc + 1 > RUN_MAX) ? RUN_MAX : acc + 1;
                        dec = 0;
                    end else if (iv > last_iv + MARGIN) begin
                        dec = (dec + 1 > RUN_MAX) ? RUN_MAX : dec + 1;
                        acc = 0;
                    end
                    if (ph != 1 && acc == ACCEL_N) begin
                        ph      = 1;
                        m_sd    = 1'b1;
                        strokes = (strokes + 1) % 65536;
                        acc     = 0;
                        dec     = 0;
                        if (drive_valid)
                            period = (cyc - last_drive > CNT_SAT) ? CNT_SAT : cyc - last_drive;
                        last_drive  = cyc;
                        drive_valid = 1'b1;
                    end else if (ph == 1 && dec == DECEL_N) begin
                        ph   = 2;
                        m_sr = 1'b1;
                        acc  = 0;
                        dec  = 0;
                    end
                end
                prev_valid = 1'b1;
                last_iv    = iv;
                anchor     = cyc;
            end else if (iv == TIMEOUT) begin
                ph          = 0;
                prev_valid  = 1'b0;
                acc         = 0;
                dec         = 0;
                drive_valid = 1'b0;
            end
        end
    end

    int sd_seen = 0;
    int sr_seen = 0;

    always @(negedge count_clock) begin : compare
        longint exp_sp;
        if (m_valid) begin
`ifdef STROKE_PERIOD_EN
            exp_sp = period;
`else
            exp_sp = 0;
`endif
            check("phase", phase, ph);
            check("idle", idle, ph == 0);
            check("start_drive", start_drive, m_sd);
            check("start_recovery", start_recovery, m_sr);
            check("stroke_count", stroke_count, strokes);
            check("last_interval", last_interval, last_iv);
            check("stroke_period", stroke_period, exp_sp);
            check("pulse_exclusive", start_drive & start_recovery, 0);
            if (start_drive === 1'b1) sd_seen++;
            if (start_recovery === 1'b1) sr_seen++;
        end
    end

    longint ref_rise = 0;

    // Raise tach 'gap' edges after the reference rise, hold it high for 'hi' edges.
    task automatic fire(input int gap, input int hi, input bit set_ref);
        while (cyc < ref_rise + gap) @(negedge count_clock);
        tach_in = 1'b1;
        if (hi >= DEBOUNCE) ev_q.push_back(cyc + EV_LAT);
        if (set_ref) ref_rise = cyc;
        repeat (hi) @(negedge count_clock);
        tach_in = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge count_clock);
    endtask

    initial begin
        int d0, r0, iv, step, kind;
        bit dir;
        reset_n = 1'b0;
        tach_in = 1'b0;
        settle(3);
        reset_n  = 1'b1;
        ref_rise = cyc;
        check("reset_phase", phase, 0);
        check("reset_idle", idle, 1);
        check("reset_strokes", stroke_count, 0);
        check("reset_last_interval", last_interval, 0);
        check("reset_stroke_period", stroke_period, 0);

        // Accelerating intervals enter DRIVE, decelerating ones enter RECOVERY.
        fire(400, 5, 1);
        fire(300, 5, 1);
        d0 = sd_seen;
        fire(200, 5, 1);
        settle(10);
        check("t2_phase_drive", phase, 1);
        check("t2_strokes", stroke_count, 1);
        check("t2_drive_pulses", sd_seen - d0, 1);
        check("t2_last_interval", last_interval, 200);
        r0 = sr_seen;
        fire(300, 5, 1);
        fire(400, 5, 1);
        settle(10);
        check("t2_phase_recovery", phase, 2);
        check("t2_recovery_pulses", sr_seen - r0, 1);

        // Neutral intervals hold the phase.
        d0 = sd_seen;
        r0 = sr_seen;
        fire(300, 5, 1);
        fire(301, 5, 1);
        fire(299, 5, 1);
        settle(10);
        check("t4_phase_hold", phase, 2);
        check("t4_no_pulses", (sd_seen - d0) + (sr_seen - r0), 0);
        check("t4_last_interval", last_interval, 299);

        // Glitch and a too-close edge are both ignored.
        fire(250, 5, 1);
        fire(10, 5, 0);
        fire(100, 2, 0);
        settle(10);
        check("t3_phase_drive", phase, 1);
        check("t3_strokes", stroke_count, 2);
        check("t3_rejected_keeps_interval", last_interval, 250);
        fire(251, 5, 1);
        settle(10);
        check("t3_next_interval", last_interval, 251);

        // Timeout from DRIVE falls back to IDLE silently; next event only seeds prev.
        d0 = sd_seen;
        r0 = sr_seen;
        settle(TIMEOUT + 100);
        check("t5_phase_idle", phase, 0);
        check("t5_idle", idle, 1);
        fire(2500, 5, 1);
        settle(10);
        check("t5_still_idle", phase, 0);
        check("t5_last_interval", last_interval, 2500);
        check("t5_no_pulses", (sd_seen - d0) + (sr_seen - r0), 0);

        // Build up to five strokes, then reset in the middle of DRIVE.
        for (int k = 0; k < 3; k++) begin
            fire(300, 5, 1);
            fire(200, 5, 1);
            if (k < 2) begin
                fire(300, 5, 1);
                fire(400, 5, 1);
            end
        end
        settle(10);
        check("t1_pre_phase", phase, 1);
        check("t1_pre_strokes", stroke_count, 5);
        reset_n = 1'b0;
        settle(1);
        reset_n  = 1'b1;
        ref_rise = cyc;
        check("t1_phase", phase, 0);
        check("t1_idle", idle, 1);
        check("t1_strokes", stroke_count, 0);
        check("t1_no_drive", start_drive, 0);
        check("t1_no_recovery", start_recovery, 0);

        // Two DRIVE entries 5000 clocks apart.
        fire(400, 5, 1);
        fire(300, 5, 1);
        fire(200, 5, 1);
        fire(800, 5, 1);
        fire(1500, 5, 1);
        fire(1400, 5, 1);
        fire(1300, 5, 1);
        settle(10);
        check("t6_strokes", stroke_count, 2);
`ifdef STROKE_PERIOD_EN
        check("t6_stroke_period", stroke_period, 5000);
`else
        check("t6_stroke_period", stroke_period, 0);
`endif

        // Shortest accepted interval.
        fire(MIN_INTERVAL, 5, 1);
        settle(10);
        check("min_interval_accept", last_interval, MIN_INTERVAL);

        // Randomized traffic: drifting intervals with glitches, short edges and timeouts.
        iv  = 300;
        dir = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if ($urandom_range(0, 3) == 0) dir = ~dir;
            step = $urandom_range(0, 40);
            iv   = dir ? iv + step : iv - step;
            if (iv < 40) iv = 40;
            if (iv > 700) iv = 700;
            kind = $urandom_range(0, 11);
            if (kind == 0) begin
                fire(($urandom_range(0, 1) == 1) ? 10 : 15, 5, 0);
            end else if (kind == 1) begin
                fire(iv / 2, $urandom_range(1, DEBOUNCE - 1), 0);
            end else if (kind == 2 && $urandom_range(0, 2) == 0) begin
                fire(TIMEOUT + 200, 5, 1);
            end
            fire(iv, 5, 1);
        end
        settle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
